// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;
    localparam int DIV_W_DEF = 8;
    localparam int DIV_MIN = 2;
    typedef enum logic [1:0] {ERR_NONE, ERR_DIV, ERR_CH} cfg_err_e;
    // Widened so that D = 2^DIV_W-1 does not overflow when adding one.
    function automatic logic [31:0] half_hi(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction
endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: divisor configuration bus between a controller and clkdiv_multi.
interface clkdiv_if import clkdiv_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int DIV_W = DIV_W_DEF
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic valid;
    logic [CH_W-1:0] ch;
    logic [DIV_W-1:0] div;
    logic ready;
    logic err;
    modport master(output valid, ch, div, input ready, err);
    modport slave(input valid, ch, div, output ready, err);
endinterface

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divided-clock channel with a pending divisor applied at phase 0.
module clkdiv_chan import clkdiv_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF,
    parameter int DIV_INIT = 5
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             calib,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             clkout,
    output logic             ce,
    output logic             pend
);
    logic [DIV_W-1:0] cnt_q, cnt_d, d_q, d_d, p_q, p_d;
    logic pv_q, pv_d, run_q, run_d, clkout_q, clkout_d, ce_q, ce_d;
    logic phase0, apply;
    // Every path that forces the counter to phase 0 is also a safe point to swap divisors.
    always_comb begin
        phase0 = !enable || calib || !run_q || cnt_q == d_q - DIV_W'(1);
        apply = pv_q && phase0;
        d_d = apply ? p_q : d_q;
        p_d = load ? load_div : p_q;
        pv_d = load || (pv_q && !apply);
        run_d = enable;
        cnt_d = phase0 ? '0 : cnt_q + DIV_W'(1);
        clkout_d = enable && (32'(cnt_d) < half_hi(32'(d_d)));
        ce_d = enable && cnt_d == '0;
    end
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            d_q <= DIV_W'(DIV_INIT);
            p_q <= '0;
            pv_q <= 1'b0;
            run_q <= 1'b0;
            clkout_q <= 1'b0;
            ce_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            d_q <= d_d;
            p_q <= p_d;
            pv_q <= pv_d;
            run_q <= run_d;
            clkout_q <= clkout_d;
            ce_q <= ce_d;
        end
    end
    assign clkout = clkout_q;
    assign ce = ce_q;
    assign pend = pv_q;
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH programmable divided clocks with enables, glitch-free divisor updates and re-phase.
module clkdiv_multi import clkdiv_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int DIV_W = DIV_W_DEF,
    parameter int DIV_INIT = 5
) (
    input  logic              hclkin,
    input  logic              resetn,
    input  logic              calib,
    input  logic [NUM_CH-1:0] enable,
    clkdiv_if.slave           cfg,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] ce
);
    logic [NUM_CH-1:0] pend, load;
    logic err_q, err_d, ch_ok, accept;
    cfg_err_e why;
    // Out-of-range writes are always consumed so a bad address can never stall the bus.
    always_comb begin
        ch_ok = 32'(cfg.ch) < NUM_CH;
        why = !ch_ok ? ERR_CH : (cfg.div < DIV_W'(DIV_MIN)) ? ERR_DIV : ERR_NONE;
        cfg.ready = !ch_ok || !pend[cfg.ch];
        accept = cfg.valid && cfg.ready;
        err_d = accept && why != ERR_NONE;
        load = (accept && why == ERR_NONE) ? NUM_CH'(1) << cfg.ch : '0;
    end
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else err_q <= err_d;
    end
    assign cfg.err = err_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_chan #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_chan (
            .hclkin(hclkin),
            .resetn(resetn),
            .calib(calib),
            .enable(enable[i]),
            .load(load[i]),
            .load_div(cfg.div),
            .clkout(clkout[i]),
            .ce(ce[i]),
            .pend(pend[i])
        );
    end
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed and random checks of clkdiv_multi against a period-start reference model.
module tb_clkdiv_multi;
    localparam int N = 4;
    logic hclkin = 1'b0;
    logic resetn = 1'b0;
    logic calib = 1'b0;
    logic [N-1:0] enable = '0;
    logic [N-1:0] clkout, ce;
    logic [2:0] clkout3, ce3;
    int total = 0;
    int bad = 0;
    int md[N], mp[N], mpv[N], mon[N], mst[N];
    int cyc = 0;
    bit merr;

    clkdiv_if #(.NUM_CH(N), .DIV_W(8)) cfg_if();
    clkdiv_if #(.NUM_CH(3), .DIV_W(8)) cfg3();

    clkdiv_multi #(.NUM_CH(N), .DIV_W(8), .DIV_INIT(5)) dut (
        .hclkin(hclkin), .resetn(resetn), .calib(calib), .enable(enable),
        .cfg(cfg_if), .clkout(clkout), .ce(ce)
    );
    clkdiv_multi #(.NUM_CH(3), .DIV_W(8), .DIV_INIT(5)) dut3 (
        .hclkin(hclkin), .resetn(resetn), .calib(1'b0), .enable(3'b000),
        .cfg(cfg3), .clkout(clkout3), .ce(ce3)
    );

    always #5 hclkin = ~hclkin;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            md[i] = 5; mp[i] = 0; mpv[i] = 0; mon[i] = 0; mst[i] = cyc;
        end
        merr = 0;
    endfunction

    // Each channel is described by when its current period began; a period ends after D cycles.
    task automatic model_edge(input logic [N-1:0] en, input bit cal, input bit v, input int c, input int dv);
        bit acc, ok;
        acc = v && (c >= N || mpv[c] == 0);
        ok = c < N && dv >= 2;
        merr = acc && !ok;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!en[i] || cal || mon[i] == 0 || cyc - mst[i] >= md[i]) begin
                if (mpv[i] != 0) begin
                    md[i] = mp[i];
                    mpv[i] = 0;
                end
                mst[i] = cyc;
            end
            mon[i] = int'(en[i]);
        end
        if (acc && ok) begin
            mp[c] = dv;
            mpv[c] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] ec, ek;
        int c;
        for (int i = 0; i < N; i++) begin
            ek[i] = enable[i] && (cyc - mst[i]) == 0;
            ec[i] = enable[i] && (cyc - mst[i]) < (md[i] + 1) / 2;
        end
        c = int'(cfg_if.ch);
        cmp({tag, ".clkout"}, 32'(clkout), 32'(ec));
        cmp({tag, ".ce"}, 32'(ce), 32'(ek));
        cmp({tag, ".err"}, 32'(cfg_if.err), 32'(merr));
        cmp({tag, ".ready"}, 32'(cfg_if.ready), 32'(mpv[c] == 0));
    endtask

    task automatic tick(input string tag);
        logic [N-1:0] en;
        bit cal, v;
        int c, dv;
        en = enable; cal = calib; v = cfg_if.valid;
        c = int'(cfg_if.ch); dv = int'(cfg_if.div);
        @(posedge hclkin);
        model_edge(en, cal, v, c, dv);
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) tick(tag);
    endtask

    task automatic write(input int c, input int dv);
        int n;
        n = 0;
        cfg_if.ch = 2'(c);
        cfg_if.div = 8'(dv);
        while (cfg_if.ready !== 1'b1 && n < 600) begin
            tick("wait_ready");
            n++;
        end
        cmp("write_ready", 32'(cfg_if.ready), 32'd1);
        cfg_if.valid = 1'b1;
        tick("write");
        cfg_if.valid = 1'b0;
    endtask

    task automatic wait_ce(input int c, input string tag);
        int n;
        n = 0;
        while (ce[c] !== 1'b1 && n < 300) begin
            tick(tag);
            n++;
        end
        cmp({tag, ".found"}, 32'(ce[c]), 32'd1);
    endtask

    initial begin
        int hi, n;
        cfg_if.valid = 1'b0; cfg_if.ch = '0; cfg_if.div = 8'd5;
        cfg3.valid = 1'b0; cfg3.ch = '0; cfg3.div = 8'd5;
        enable = '1;
        model_reset();
        #3;
        cmp("rst.clkout", 32'(clkout), 32'd0);
        cmp("rst.ce", 32'(ce), 32'd0);
        cmp("rst.err", 32'(cfg_if.err), 32'd0);
        cmp("rst.ready", 32'(cfg_if.ready), 32'd1);
        #4 resetn = 1'b1;
        tick("first");
        cmp("first.ce_all", 32'(ce), 32'hF);
        cmp("first.clk_all", 32'(clkout), 32'hF);
        run(20, "div5");

        run(2, "pre_wr");
        write(1, 4);
        cmp("ch1.ready_low", 32'(cfg_if.ready), 32'd0);
        run(16, "div4");

        write(0, 1);
        cmp("err_div1", 32'(cfg_if.err), 32'd1);
        tick("err_div1_after");
        cmp("err_div1_clear", 32'(cfg_if.err), 32'd0);
        write(2, 0);
        cmp("err_div0", 32'(cfg_if.err), 32'd1);
        run(12, "after_bad");

        cfg3.ch = 2'd3; cfg3.valid = 1'b1;
        cmp("bad_ch.ready", 32'(cfg3.ready), 32'd1);
        tick("bad_ch");
        cfg3.valid = 1'b0;
        cmp("bad_ch.err", 32'(cfg3.err), 32'd1);
        tick("bad_ch_after");
        cmp("bad_ch.clear", 32'(cfg3.err), 32'd0);

        write(2, 255);
        run(6, "div255_apply");
        wait_ce(2, "div255_sync");
        hi = int'(clkout[2]);
        repeat (254) begin
            tick("div255");
            hi += int'(clkout[2]);
        end
        cmp("div255.high", 32'(hi), 32'd128);
        tick("div255_wrap");
        cmp("div255.period", 32'(ce[2]), 32'd1);

        write(0, 3);
        write(2, 7);
        calib = 1'b1;
        tick("calib");
        calib = 1'b0;
        cmp("calib.ce", 32'(ce), 32'hF);
        n = 0;
        do begin
            tick("coincide");
            n++;
        end while (!(ce[0] && ce[2]) && n < 100);
        cmp("coincide.period", 32'(n), 32'd21);
        calib = 1'b1;
        run(3, "calib_held");
        calib = 1'b0;

        wait_ce(3, "ch3_sync");
        tick("ch3_high");
        enable[3] = 1'b0;
        tick("ch3_off");
        cmp("ch3_off.clk", 32'(clkout[3]), 32'd0);
        write(3, 2);
        enable[3] = 1'b1;
        tick("ch3_on");
        cmp("ch3_on.ce", 32'(ce[3]), 32'd1);
        run(2, "ch3_div2");
        cmp("ch3_div2.ce", 32'(ce[3]), 32'd1);

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(15) == 0) enable[$urandom_range(N - 1)] ^= 1'b1;
            calib = ($urandom_range(31) == 0);
            cfg_if.valid = ($urandom_range(3) == 0);
            cfg_if.ch = 2'($urandom_range(N - 1));
            cfg_if.div = 8'($urandom_range(9));
            tick("rand");
        end
        cfg_if.valid = 1'b0; calib = 1'b0; enable = '1;
        run(10, "settle");

        cfg_if.ch = '0;
        while (cfg_if.ready !== 1'b1 && n < 1000) begin
            tick("rst_wait");
            n++;
        end
        write(0, 9);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        cmp("arst.clkout", 32'(clkout), 32'd0);
        cmp("arst.ce", 32'(ce), 32'd0);
        cmp("arst.err", 32'(cfg_if.err), 32'd0);
        cmp("arst.ready", 32'(cfg_if.ready), 32'd1);
        #1 resetn = 1'b1;
        tick("arst_first");
        cmp("arst_first.ce", 32'(ce), 32'hF);
        run(20, "arst_div5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
